coin_accumulator: RTL and testbench
===================================

Name: coin_accumulator

Overview:
Upstream stage of the vending machine FSM. Accepts coins from the coin sensor over a valid/ready handshake, validates each coin code, and accumulates the running credit. It drives the 7-bit total-coin-value bus consumed by the vending FSM. It also rejects invalid or overflowing coins, refunds credit on inactivity timeout, and freezes credit while the downstream block dispenses.

Parameters:
COIN1_VALUE, 7'd1, value of coin code 3'b001
COIN2_VALUE, 7'd2, value of coin code 3'b010
COIN5_VALUE, 7'd5, value of coin code 3'b011
COIN10_VALUE, 7'd10, value of coin code 3'b100
COIN20_VALUE, 7'd20, value of coin code 3'b101
MAX_TOTAL, 7'd127, maximum credit; a coin that would exceed it is rejected
TIMEOUT_CYCLES, 16'd1000, idle cycles in COLLECT before auto-refund (must be >= 2)

Ports:
i_clk  input  1  clock
i_rst  input  1  reset, asynchronous, active-high
i_coin_valid  input  1  coin sensor presents a coin; held until accepted
i_coin_code  input  3  coin type; 000, 110 and 111 are invalid
o_coin_ready  output  1  block can take a coin this cycle
i_accept_en  input  1  downstream is in a product-selection state and is awaiting payment
i_lock  input  1  downstream is committing the purchase; freeze credit
i_clear  input  1  downstream finished (dispense or cancel); zero credit
o_total_coin_value  output  7  accumulated credit, feeds the vending FSM
o_coin_accepted  output  1  1-cycle pulse, coin added
o_coin_rejected  output  1  1-cycle pulse, coin returned to the tray
o_timeout  output  1  1-cycle pulse, credit auto-refunded
o_refund_value  output  7  refunded credit; valid only while o_timeout is high, else 0
o_state  output  2  current state encoding

Behaviour:
- Reset: state IDLE; all outputs 0; timeout counter 0.
- States (2-bit): IDLE=00 (credit 0), COLLECT=01 (credit >0), REJECT=10 (1-cycle), LOCK=11.
- o_coin_ready = (state is IDLE or COLLECT) && i_accept_en && !i_lock && !i_clear. This is combinational.
- Handshake: a coin is taken in cycle N when i_coin_valid && o_coin_ready. The evaluation result is registered and appears at N+1.
- Evaluation: sum = {1'b0,total} + coin value, computed at 8 bits. If the code is valid and sum <= MAX_TOTAL: total <= sum[6:0], o_coin_accepted pulses at N+1, state -> COLLECT, timeout counter -> 0. Otherwise: total is unchanged, state -> REJECT for exactly one cycle with o_coin_rejected high, then it returns to IDLE if total==0, else COLLECT.
- REJECT: ready=0. The timeout counter holds.
- COLLECT: the timeout counter increments on every cycle in which no coin is taken. When it reaches TIMEOUT_CYCLES-1: o_timeout pulses next cycle, o_refund_value = previous total for that cycle, total -> 0, state -> IDLE, counter -> 0.
- i_lock in IDLE/COLLECT -> LOCK next cycle. In LOCK: ready=0, total held stable, counter frozen. LOCK is left only via i_clear.
- i_clear is the highest priority after reset, in any state. Next cycle: total=0, state IDLE, counter 0, no accepted/rejected/timeout pulse. A coin presented in the same cycle is not taken, because ready is forced low.
- i_clear and timeout terminal count in the same cycle: clear wins, and o_timeout stays low.
- i_accept_en low: ready=0 and coins wait. The timeout counter still runs in COLLECT.
- An asynchronous reset mid-operation drops credit immediately. No refund pulse is produced.
- Exactly one of accepted/rejected/timeout may be high in any cycle.

Decomposition:
- Shared package: state encodings, the coin code constants 3'b001..3'b101, and the default coin values. The vending FSM package reuses these.
- One natural sub-module: coin_value_decoder, a combinational map from code to {valid, value[6:0]} using the value parameters.

Test Plan:
- Reset, then accept_en=1; insert 001, 011, 100 back-to-back with valid held -> three accepted pulses; total 1, 6, 16; state COLLECT.
- Insert code 110 with total=16 -> o_coin_rejected for 1 cycle, state REJECT then COLLECT; total stays 16.
- Build total=120 and insert 101 (20) -> rejected (140>127); then insert 011 -> total 125.
- With TIMEOUT_CYCLES=8 and total=35, send no coins -> 8 cycles later o_timeout=1, o_refund_value=35; then total 0, state IDLE.
- Total=50; assert i_lock -> LOCK, ready=0, and a presented coin waits. Assert i_clear with coin valid -> total 0, IDLE, no accept pulse; the coin is accepted after accept_en.
- Total=40; assert i_rst asynchronously mid-cycle -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/coin_accumulator_pkg.sv
// Shared definitions for the coin path: FSM state encodings, coin codes
// and the default coin values. The downstream vending FSM imports these as well.
package coin_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_REJECT  = 2'b10,
    ST_LOCK    = 2'b11
  } state_e;

  localparam logic [2:0] COIN_CODE_1  = 3'b001;
  localparam logic [2:0] COIN_CODE_2  = 3'b010;
  localparam logic [2:0] COIN_CODE_5  = 3'b011;
  localparam logic [2:0] COIN_CODE_10 = 3'b100;
  localparam logic [2:0] COIN_CODE_20 = 3'b101;

  localparam logic [6:0] DEF_COIN1_VALUE  = 7'd1;
  localparam logic [6:0] DEF_COIN2_VALUE  = 7'd2;
  localparam logic [6:0] DEF_COIN5_VALUE  = 7'd5;
  localparam logic [6:0] DEF_COIN10_VALUE = 7'd10;
  localparam logic [6:0] DEF_COIN20_VALUE = 7'd20;

  localparam logic [6:0]  DEF_MAX_TOTAL      = 7'd127;
  localparam logic [15:0] DEF_TIMEOUT_CYCLES = 16'd1000;

endpackage

// File: rtl/coin_accumulator_value_decoder.sv
// Combinational map from a coin code to its credit value.
// Codes outside the five known coins decode as invalid with value 0.
module coin_value_decoder
  import coin_accumulator_pkg::*;
#(
  parameter logic [6:0] COIN1_VALUE  = DEF_COIN1_VALUE,
  parameter logic [6:0] COIN2_VALUE  = DEF_COIN2_VALUE,
  parameter logic [6:0] COIN5_VALUE  = DEF_COIN5_VALUE,
  parameter logic [6:0] COIN10_VALUE = DEF_COIN10_VALUE,
  parameter logic [6:0] COIN20_VALUE = DEF_COIN20_VALUE
) (
  input  logic [2:0] code,
  output logic       valid,
  output logic [6:0] value
);

  // Code lookup; unknown codes fall through to invalid.
  always_comb begin
    valid = 1'b1;
    value = 7'd0;
    case (code)
      COIN_CODE_1:  value = COIN1_VALUE;
      COIN_CODE_2:  value = COIN2_VALUE;
      COIN_CODE_5:  value = COIN5_VALUE;
      COIN_CODE_10: value = COIN10_VALUE;
      COIN_CODE_20: value = COIN20_VALUE;
      default:      valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/coin_accumulator.sv
// Coin accumulator: takes coins over a valid/ready handshake, validates
// and sums them into the credit bus, rejects bad or overflowing coins,
// refunds on inactivity and freezes credit while downstream commits.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | no credit, waiting for the first coin
// COLLECT | credit > 0, inactivity timer running
// REJECT  | one cycle, coin returned to the tray, credit unchanged
// LOCK    | downstream committing, credit frozen until clear
module coin_accumulator
  import coin_accumulator_pkg::*;
#(
  parameter logic [6:0]  COIN1_VALUE    = DEF_COIN1_VALUE,
  parameter logic [6:0]  COIN2_VALUE    = DEF_COIN2_VALUE,
  parameter logic [6:0]  COIN5_VALUE    = DEF_COIN5_VALUE,
  parameter logic [6:0]  COIN10_VALUE   = DEF_COIN10_VALUE,
  parameter logic [6:0]  COIN20_VALUE   = DEF_COIN20_VALUE,
  parameter logic [6:0]  MAX_TOTAL      = DEF_MAX_TOTAL,
  parameter logic [15:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_coin_valid,
  input  logic [2:0] i_coin_code,
  output logic       o_coin_ready,
  input  logic       i_accept_en,
  input  logic       i_lock,
  input  logic       i_clear,
  output logic [6:0] o_total_coin_value,
  output logic       o_coin_accepted,
  output logic       o_coin_rejected,
  output logic       o_timeout,
  output logic [6:0] o_refund_value,
  output logic [1:0] o_state
);

  state_e      state_q, state_d;
  logic [6:0]  total_q, total_d;
  logic [15:0] cnt_q, cnt_d;
  logic        accepted_q, accepted_d;
  logic        rejected_q, rejected_d;
  logic        timeout_q, timeout_d;
  logic [6:0]  refund_q, refund_d;

  logic        coin_valid;
  logic [6:0]  coin_value;
  logic [7:0]  sum;
  logic        coin_taken;
  logic        timer_tc;

  coin_value_decoder #(
    .COIN1_VALUE  (COIN1_VALUE),
    .COIN2_VALUE  (COIN2_VALUE),
    .COIN5_VALUE  (COIN5_VALUE),
    .COIN10_VALUE (COIN10_VALUE),
    .COIN20_VALUE (COIN20_VALUE)
  ) u_decoder (
    .code  (i_coin_code),
    .valid (coin_valid),
    .value (coin_value)
  );

  // Ready is combinational so a held coin is taken the same cycle conditions allow.
  assign o_coin_ready = ((state_q == ST_IDLE) || (state_q == ST_COLLECT)) &&
                        i_accept_en && !i_lock && !i_clear;
  assign coin_taken   = i_coin_valid && o_coin_ready;
  // Nine-bit-free overflow check: the carry lands in sum[7].
  assign sum          = {1'b0, total_q} + {1'b0, coin_value};
  assign timer_tc     = (cnt_q == (TIMEOUT_CYCLES - 16'd1));

  // Next-state and registered-output logic; clear overrides everything.
  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    cnt_d      = cnt_q;
    accepted_d = 1'b0;
    rejected_d = 1'b0;
    timeout_d  = 1'b0;
    refund_d   = 7'd0;
    if (i_clear) begin
      state_d = ST_IDLE;
      total_d = 7'd0;
      cnt_d   = 16'd0;
    end else begin
      case (state_q)
        ST_IDLE, ST_COLLECT: begin
          if (i_lock) begin
            state_d = ST_LOCK;
          end else if (coin_taken) begin
            if (coin_valid && (sum <= {1'b0, MAX_TOTAL})) begin
              total_d    = sum[6:0];
              accepted_d = 1'b1;
              state_d    = ST_COLLECT;
              cnt_d      = 16'd0;
            end else begin
              rejected_d = 1'b1;
              state_d    = ST_REJECT;
            end
          end else if (state_q == ST_COLLECT) begin
            if (timer_tc) begin
              timeout_d = 1'b1;
              refund_d  = total_q;
              total_d   = 7'd0;
              state_d   = ST_IDLE;
              cnt_d     = 16'd0;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
        end
        ST_REJECT: state_d = (total_q == 7'd0) ? ST_IDLE : ST_COLLECT;
        ST_LOCK:   state_d = ST_LOCK;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers; reset drops credit without any refund pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      total_q    <= 7'd0;
      cnt_q      <= 16'd0;
      accepted_q <= 1'b0;
      rejected_q <= 1'b0;
      timeout_q  <= 1'b0;
      refund_q   <= 7'd0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      cnt_q      <= cnt_d;
      accepted_q <= accepted_d;
      rejected_q <= rejected_d;
      timeout_q  <= timeout_d;
      refund_q   <= refund_d;
    end
  end

  assign o_total_coin_value = total_q;
  assign o_coin_accepted    = accepted_q;
  assign o_coin_rejected    = rejected_q;
  assign o_timeout          = timeout_q;
  assign o_refund_value     = refund_q;
  assign o_state            = state_q;

endmodule

// File: tb/tb_coin_accumulator.sv
// Self-checking bench for coin_accumulator: directed scenarios followed by
// randomized traffic, all compared every cycle against a credit-level model.
module tb_coin_accumulator;

  localparam int TO = 8;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_coin_valid = 1'b0;
  logic [2:0] i_coin_code = 3'd0;
  logic       i_accept_en = 1'b0;
  logic       i_lock = 1'b0;
  logic       i_clear = 1'b0;
  logic       o_coin_ready;
  logic [6:0] o_total_coin_value;
  logic       o_coin_accepted;
  logic       o_coin_rejected;
  logic       o_timeout;
  logic [6:0] o_refund_value;
  logic [1:0] o_state;

  int checks = 0;
  int failures = 0;

  coin_accumulator #(.TIMEOUT_CYCLES(16'(TO))) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_coin_valid       (i_coin_valid),
    .i_coin_code        (i_coin_code),
    .o_coin_ready       (o_coin_ready),
    .i_accept_en        (i_accept_en),
    .i_lock             (i_lock),
    .i_clear            (i_clear),
    .o_total_coin_value (o_total_coin_value),
    .o_coin_accepted    (o_coin_accepted),
    .o_coin_rejected    (o_coin_rejected),
    .o_timeout          (o_timeout),
    .o_refund_value     (o_refund_value),
    .o_state            (o_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle (no credit), 1 collecting, 2 coin being returned, 3 frozen
  int m_phase = 0, m_credit = 0, m_idle = 0;
  int m_acc = 0, m_rej = 0, m_to = 0, m_refund = 0;

  function automatic int coin_val(input logic [2:0] c);
    case (c)
      3'd1: return 1;
      3'd2: return 2;
      3'd3: return 5;
      3'd4: return 10;
      3'd5: return 20;
      default: return 0;
    endcase
  endfunction

  function automatic int model_ready();
    return ((m_phase == 0 || m_phase == 1) && i_accept_en && !i_lock && !i_clear) ? 1 : 0;
  endfunction

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_phase = 0; m_credit = 0; m_idle = 0;
      m_acc = 0; m_rej = 0; m_to = 0; m_refund = 0;
    end else begin
      int v;
      int rdy;
      rdy = model_ready();
      v = coin_val(i_coin_code);
      m_acc = 0; m_rej = 0; m_to = 0; m_refund = 0;
      if (i_clear) begin
        m_credit = 0; m_phase = 0; m_idle = 0;
      end else if (m_phase == 3) begin
        m_phase = 3;
      end else if (m_phase == 2) begin
        m_phase = (m_credit == 0) ? 0 : 1;
      end else if (i_lock) begin
        m_phase = 3;
      end else if (rdy == 1 && i_coin_valid) begin
        if (v > 0 && m_credit + v <= 127) begin
          m_credit += v; m_acc = 1; m_phase = 1; m_idle = 0;
        end else begin
          m_rej = 1; m_phase = 2;
        end
      end else if (m_phase == 1) begin
        m_idle++;
        if (m_idle == TO) begin
          m_to = 1; m_refund = m_credit; m_credit = 0; m_phase = 0; m_idle = 0;
        end
      end
    end
  end

  // Compare every cycle on the falling edge, away from the sampling edge.
  always @(negedge i_clk) begin
    chk("ready", int'(o_coin_ready), model_ready());
    chk("total", int'(o_total_coin_value), m_credit);
    chk("state", int'(o_state), m_phase);
    chk("accepted", int'(o_coin_accepted), m_acc);
    chk("rejected", int'(o_coin_rejected), m_rej);
    chk("timeout", int'(o_timeout), m_to);
    chk("refund", int'(o_refund_value), m_refund);
    if ((int'(o_coin_accepted) + int'(o_coin_rejected) + int'(o_timeout)) > 1)
      chk("one_pulse", 2, 1);
  end

  task automatic cyc(input logic v, input logic [2:0] c, input logic en,
                     input logic lk, input logic clr);
    i_coin_valid = v; i_coin_code = c; i_accept_en = en; i_lock = lk; i_clear = clr;
    @(posedge i_clk); #1;
  endtask

  initial begin
    logic taken;
    @(posedge i_clk); @(posedge i_clk); #1;
    chk("rst_total", int'(o_total_coin_value), 0);
    chk("rst_state", int'(o_state), 0);
    i_rst = 1'b0;

    // back-to-back accepted coins
    cyc(1, 3'b001, 1, 0, 0);
    chk("a1_total", int'(o_total_coin_value), 1); chk("a1_acc", int'(o_coin_accepted), 1);
    cyc(1, 3'b011, 1, 0, 0);
    chk("a2_total", int'(o_total_coin_value), 6);
    cyc(1, 3'b100, 1, 0, 0);
    chk("a3_total", int'(o_total_coin_value), 16); chk("a3_state", int'(o_state), 1);
    chk("model_16", m_credit, 16);

    // invalid code
    cyc(1, 3'b110, 1, 0, 0);
    chk("inv_rej", int'(o_coin_rejected), 1); chk("inv_state", int'(o_state), 2);
    chk("inv_total", int'(o_total_coin_value), 16);
    cyc(0, 3'b000, 1, 0, 0);
    chk("inv_back", int'(o_state), 1); chk("inv_rej_off", int'(o_coin_rejected), 0);

    // overflow rejection at 120 + 20
    for (int i = 0; i < 5; i++) cyc(1, 3'b101, 1, 0, 0);
    cyc(1, 3'b010, 1, 0, 0);
    cyc(1, 3'b010, 1, 0, 0);
    chk("ovf_120", int'(o_total_coin_value), 120);
    cyc(1, 3'b101, 1, 0, 0);
    chk("ovf_rej", int'(o_coin_rejected), 1); chk("ovf_total", int'(o_total_coin_value), 120);
    cyc(0, 3'b000, 1, 0, 0);
    cyc(1, 3'b011, 1, 0, 0);
    chk("ovf_125", int'(o_total_coin_value), 125); chk("model_125", m_credit, 125);

    // inactivity timeout with 35 credit
    cyc(0, 3'b000, 1, 0, 1);
    chk("clr_total", int'(o_total_coin_value), 0);
    cyc(1, 3'b101, 1, 0, 0);
    cyc(1, 3'b100, 1, 0, 0);
    cyc(1, 3'b011, 1, 0, 0);
    for (int i = 0; i < TO - 1; i++) cyc(0, 3'b000, 1, 0, 0);
    chk("to_early", int'(o_timeout), 0);
    cyc(0, 3'b000, 1, 0, 0);
    chk("to_pulse", int'(o_timeout), 1); chk("to_refund", int'(o_refund_value), 35);
    chk("to_total", int'(o_total_coin_value), 0); chk("to_state", int'(o_state), 0);
    cyc(0, 3'b000, 1, 0, 0);
    chk("to_refund_off", int'(o_refund_value), 0);

    // lock with a waiting coin, then clear
    cyc(1, 3'b101, 1, 0, 0);
    cyc(1, 3'b101, 1, 0, 0);
    cyc(1, 3'b100, 1, 0, 0);
    cyc(1, 3'b001, 1, 1, 0);
    chk("lock_state", int'(o_state), 3); chk("lock_total", int'(o_total_coin_value), 50);
    for (int i = 0; i < 3; i++) cyc(1, 3'b001, 1, 0, 0);
    chk("lock_ready", int'(o_coin_ready), 0); chk("lock_hold", int'(o_total_coin_value), 50);
    cyc(1, 3'b001, 1, 0, 1);
    chk("lclr_total", int'(o_total_coin_value), 0); chk("lclr_state", int'(o_state), 0);
    chk("lclr_acc", int'(o_coin_accepted), 0);
    cyc(1, 3'b001, 0, 0, 0);
    chk("noen_acc", int'(o_coin_accepted), 0);
    cyc(1, 3'b001, 1, 0, 0);
    chk("en_acc", int'(o_coin_accepted), 1); chk("en_total", int'(o_total_coin_value), 1);

    // asynchronous reset mid-cycle
    cyc(0, 3'b000, 1, 0, 1);
    cyc(1, 3'b101, 1, 0, 0);
    cyc(1, 3'b101, 1, 0, 0);
    chk("ar_40", int'(o_total_coin_value), 40);
    i_coin_valid = 0;
    #2 i_rst = 1'b1;
    #1;
    chk("ar_total", int'(o_total_coin_value), 0); chk("ar_state", int'(o_state), 0);
    chk("ar_to", int'(o_timeout), 0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // randomized traffic
    i_coin_valid = 0;
    for (int i = 0; i < 4000; i++) begin
      #3;
      taken = i_coin_valid && o_coin_ready;
      @(posedge i_clk); #1;
      if (!i_coin_valid || taken) begin
        i_coin_valid = ($urandom % 4) != 0;
        i_coin_code  = 3'($urandom % 8);
      end
      i_accept_en = ($urandom % 8) != 0;
      i_lock      = ($urandom % 40) == 0;
      i_clear     = ($urandom % 30) == 0;
      if (($urandom % 50) == 0) begin
        i_coin_valid = 0;
        repeat (TO + 2) begin
          @(posedge i_clk); #1;
        end
      end
    end

    @(posedge i_clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
